// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command responder: opcodes, status codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro UART_CMD_CHECKSUM_EN adds the checksum-byte state.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } operation_t;

    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_CARRY  = 8'h01;
    localparam logic [7:0] ST_BADCHK = 8'h40;
    localparam logic [7:0] ST_BADOP  = 8'h80;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
`ifdef UART_CMD_CHECKSUM_EN
        S_GET_CHK,
`endif
        S_EXEC,
        S_SEND_STAT,
        S_WAIT_STAT,
        S_SEND_RES,
        S_WAIT_RES
    } state_t;

    // Expected checksum byte of a frame: XOR of opcode and both operands.
    function automatic logic [7:0] frame_chk(input logic [7:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        return op ^ a ^ b;
    endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Byte-level link between the responder and the UART wrapper (rx side and tx handshake).
// Latency: n/a (wires only).
// Backpressure: tx_busy from the wrapper holds off the next tx_valid.
// Ports: rx_data/rx_valid (received byte, done strobe), tx_data/tx_valid (send request),
//        tx_busy (transmitter busy). master = responder side, slave = UART wrapper side.
interface uart_cmd_responder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  tx_busy,
        output tx_data,
        output tx_valid
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output tx_busy,
        input  tx_data,
        input  tx_valid
    );
endinterface

// File: rtl/uart_cmd_alu.sv
// Combinational executor for one command: opcode/A/B -> result byte and status byte.
// Latency: 0 cycles (result registered by the caller in its EXEC state).
// Backpressure: none.
// Ports: op, a, b in (8 bits each); result, status out (8 bits each).
module uart_cmd_alu
    import uart_cmd_pkg::*;
(
    input  logic [7:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result,
    output logic [7:0] status
);

    logic [8:0] sum;
    logic [8:0] diff;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = 8'h00;
        status = ST_BADOP;
        // Any set bit above the operation field makes the opcode invalid.
        if (op[7:2] == 6'd0) begin
            case (operation_t'(op[1:0]))
                OP_NOP: begin
                    result = a;
                    status = ST_OK;
                end
                OP_ADD: begin
                    result = sum[7:0];
                    status = sum[8] ? ST_CARRY : ST_OK;
                end
                OP_SUB: begin
                    // Bit 8 of the 9-bit difference is the borrow (A < B).
                    result = diff[7:0];
                    status = diff[8] ? ST_CARRY : ST_OK;
                end
                default: begin
                    result = 8'h00;
                    status = ST_BADOP;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Frames received bytes into commands, executes them and sends a status+result reply.
// Latency: tx_valid rises 2 cycles after the strobe of the last frame byte.
// Backpressure: each reply byte is held on tx_valid until tx_busy is seen, then waits for tx_busy low.
// Ports: clk, rst_n (async active-low); bus (uart_cmd_responder_if.master); busy, last_status,
//        timeout_flag, rx_drop status outputs. Param TIMEOUT_CYCLES = max inter-byte gap.
// Optional: define UART_CMD_CHECKSUM_EN for a 4-byte frame with trailing op^A^B checksum.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 104160
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_cmd_responder_if.master   bus,
    output logic                   busy,
    output logic [7:0]             last_status,
    output logic                   timeout_flag,
    output logic                   rx_drop
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic             rx_valid_q;
    logic             rx_stb;
    logic [CNT_W-1:0] gap_cnt;
    logic             in_frame;
    logic             expired;
    logic [7:0]       op_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [7:0]       res_q;
    logic [7:0]       stat_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic [7:0]       alu_res;
    logic [7:0]       alu_stat;
    logic [7:0]       exec_res;
    logic [7:0]       exec_stat;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]       chk_q;
`endif

    // The receiver holds out_RXNE high for a while; only its rising edge marks a new byte.
    assign rx_stb = bus.rx_valid & ~rx_valid_q;

`ifdef UART_CMD_CHECKSUM_EN
    assign in_frame = (state == S_GET_A) || (state == S_GET_B) || (state == S_GET_CHK);
`else
    assign in_frame = (state == S_GET_A) || (state == S_GET_B);
`endif
    assign expired  = in_frame && (gap_cnt == CNT_LAST);

    assign busy        = (state != S_IDLE);
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;

    uart_cmd_alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res),
        .status (alu_stat)
    );

    // A bad checksum overrides whatever the ALU reports, including a bad opcode.
    always_comb begin
        exec_res  = alu_res;
        exec_stat = alu_stat;
`ifdef UART_CMD_CHECKSUM_EN
        if (chk_q != frame_chk(op_q, a_q, b_q)) begin
            exec_res  = 8'h00;
            exec_stat = ST_BADCHK;
        end
`endif
    end

    // Inter-byte gap counter: only runs while a frame is partially received.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            rx_valid_q <= bus.rx_valid;
            if (!in_frame || rx_stb) begin
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            op_q         <= 8'h00;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
            chk_q        <= 8'h00;
`endif
            res_q        <= 8'h00;
            stat_q       <= 8'h00;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            last_status  <= 8'h00;
            timeout_flag <= 1'b0;
            rx_drop      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_stb) begin
                        op_q  <= bus.rx_data;
                        state <= S_GET_A;
                    end
                end
                // Expiry is tested before the strobe so a byte landing on the
                // expiry cycle is discarded along with the partial frame.
                S_GET_A: begin
                    if (expired) begin
                        timeout_flag <= 1'b1;
                        state        <= S_IDLE;
                    end else if (rx_stb) begin
                        a_q   <= bus.rx_data;
                        state <= S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (expired) begin
                        timeout_flag <= 1'b1;
                        state        <= S_IDLE;
                    end else if (rx_stb) begin
                        b_q   <= bus.rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                        state <= S_GET_CHK;
`else
                        state <= S_EXEC;
`endif
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                S_GET_CHK: begin
                    if (expired) begin
                        timeout_flag <= 1'b1;
                        state        <= S_IDLE;
                    end else if (rx_stb) begin
                        chk_q <= bus.rx_data;
                        state <= S_EXEC;
                    end
                end
`endif
                S_EXEC: begin
                    res_q      <= exec_res;
                    stat_q     <= exec_stat;
                    tx_data_q  <= exec_stat;
                    // Do not raise a request into a transmitter that is still busy.
                    tx_valid_q <= ~bus.tx_busy;
                    state      <= S_SEND_STAT;
                end
                S_SEND_STAT: begin
                    if (tx_valid_q && bus.tx_busy) begin
                        tx_valid_q <= 1'b0;
                        state      <= S_WAIT_STAT;
                    end else if (!tx_valid_q && !bus.tx_busy) begin
                        tx_valid_q <= 1'b1;
                    end
                end
                S_WAIT_STAT: begin
                    if (!bus.tx_busy) begin
                        tx_data_q  <= res_q;
                        tx_valid_q <= 1'b1;
                        state      <= S_SEND_RES;
                    end
                end
                S_SEND_RES: begin
                    if (tx_valid_q && bus.tx_busy) begin
                        tx_valid_q <= 1'b0;
                        state      <= S_WAIT_RES;
                    end else if (!tx_valid_q && !bus.tx_busy) begin
                        tx_valid_q <= 1'b1;
                    end
                end
                S_WAIT_RES: begin
                    if (!bus.tx_busy) begin
                        last_status  <= stat_q;
                        timeout_flag <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase

            // Bytes arriving while a command executes or replies are lost; flag it.
            if (rx_stb && (state != S_IDLE) && !in_frame) begin
                rx_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: frames, latency, timeout, drop, stall, reset.
// Latency: n/a.
// Backpressure: the bench plays the UART transmitter via tx_busy.
module tb_uart_cmd_responder;

    localparam int TO = 200;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [7:0] last_status;
    logic       timeout_flag;
    logic       rx_drop;

    int checks;
    int errors;

    uart_cmd_responder_if bus_if ();

    uart_cmd_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .busy         (busy),
        .last_status  (last_status),
        .timeout_flag (timeout_flag),
        .rx_drop      (rx_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // One byte: rx_valid high for one cycle, returns at the negedge after the strobe cycle.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        send_byte(op);
        send_byte(a);
        send_byte(b);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(op ^ a ^ b);
`endif
    endtask

    // Accept one reply byte as the transmitter would: wait for tx_valid, go busy for a few cycles.
    task automatic get_byte(input string tag, output logic [7:0] d);
        bit got;
        got = 1'b0;
        d   = 8'hxx;
        for (int i = 0; i < 100; i++) begin
            if (bus_if.tx_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s: tx_valid observed 0 for 100 cycles expected 1", tag);
        end
        if (got) begin
            d = bus_if.tx_data;
            bus_if.tx_busy = 1'b1;
            repeat (3) @(negedge clk);
            bus_if.tx_busy = 1'b0;
        end
    endtask

    task automatic do_frame(input string tag, input logic [7:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] est, input logic [7:0] eres);
        logic [7:0] d;
        send_frame(op, a, b);
        get_byte({tag, "_stat_wait"}, d);
        check8({tag, "_status"}, d, est);
        get_byte({tag, "_res_wait"}, d);
        check8({tag, "_result"}, d, eres);
        @(negedge clk);
        check8({tag, "_last_status"}, last_status, est);
        check8({tag, "_idle"}, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        logic [7:0] d;
        bit         saw_tx;
        bit         stable;

        checks = 0;
        errors = 0;
        rst_n           = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        bus_if.tx_busy  = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check8("rst_tx_valid", {7'd0, bus_if.tx_valid}, 8'h00);
        check8("rst_tx_data", bus_if.tx_data, 8'h00);
        check8("rst_busy", {7'd0, busy}, 8'h00);
        check8("rst_last_status", last_status, 8'h00);
        check8("rst_timeout_flag", {7'd0, timeout_flag}, 8'h00);
        check8("rst_rx_drop", {7'd0, rx_drop}, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First add frame with an exact latency check on tx_valid.
        send_byte(8'h01);
        send_byte(8'h10);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h22);
        send_byte(8'h33);
`else
        send_byte(8'h22);
`endif
        check8("lat_exec_no_valid", {7'd0, bus_if.tx_valid}, 8'h00);
        check8("lat_busy", {7'd0, busy}, 8'h01);
        @(negedge clk);
        check8("lat_valid_2cyc", {7'd0, bus_if.tx_valid}, 8'h01);
        get_byte("add1_stat_wait", d);
        check8("add1_status", d, 8'h00);
        get_byte("add1_res_wait", d);
        check8("add1_result", d, 8'h32);
        @(negedge clk);
        check8("add1_last_status", last_status, 8'h00);

        do_frame("add_carry", 8'h01, 8'hF0, 8'h20, 8'h01, 8'h10);
        do_frame("sub_borrow", 8'h02, 8'h05, 8'h07, 8'h01, 8'hFE);
        do_frame("nop", 8'h00, 8'h5A, 8'h00, 8'h00, 8'h5A);
        do_frame("bad_op", 8'h07, 8'h01, 8'h01, 8'h80, 8'h00);
        do_frame("bad_op3", 8'h03, 8'h09, 8'h02, 8'h80, 8'h00);

        // Inter-byte timeout: partial frame, then silence.
        send_byte(8'h01);
        send_byte(8'h10);
        saw_tx = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk);
            if (bus_if.tx_valid === 1'b1) saw_tx = 1'b1;
        end
        check8("to_not_yet", {7'd0, timeout_flag}, 8'h00);
        check8("to_still_busy", {7'd0, busy}, 8'h01);
        @(negedge clk);
        check8("to_flag_set", {7'd0, timeout_flag}, 8'h01);
        check8("to_back_idle", {7'd0, busy}, 8'h00);
        repeat (5) @(negedge clk);
        if (bus_if.tx_valid === 1'b1) saw_tx = 1'b1;
        check8("to_no_tx", {7'd0, saw_tx}, 8'h00);
        do_frame("after_to", 8'h01, 8'h01, 8'h01, 8'h00, 8'h02);
        check8("to_flag_cleared", {7'd0, timeout_flag}, 8'h00);
        check8("no_drop_yet", {7'd0, rx_drop}, 8'h00);

        // Stalled transmitter and a byte arriving during the reply.
        send_frame(8'h01, 8'h03, 8'h04);
        repeat (2) @(negedge clk);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'h00) stable = 1'b0;
            @(negedge clk);
        end
        check8("stall_valid_held", {7'd0, stable}, 8'h01);
        bus_if.tx_busy = 1'b1;
        @(negedge clk);
        bus_if.rx_data  = 8'hAA;
        bus_if.rx_valid = 1'b1;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus_if.tx_valid !== 1'b0 || bus_if.tx_data !== 8'h00) stable = 1'b0;
            @(negedge clk);
        end
        check8("busy_no_merge", {7'd0, stable}, 8'h01);
        check8("drop_set", {7'd0, rx_drop}, 8'h01);
        bus_if.tx_busy = 1'b0;
        get_byte("drop_res_wait", d);
        check8("drop_result", d, 8'h07);
        @(negedge clk);
        check8("drop_last_status", last_status, 8'h00);
        check8("drop_sticky", {7'd0, rx_drop}, 8'h01);

`ifdef UART_CMD_CHECKSUM_EN
        // Checksum mismatch outranks everything else.
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h22);
        send_byte(8'h00);
        get_byte("badchk_stat_wait", d);
        check8("badchk_status", d, 8'h40);
        get_byte("badchk_res_wait", d);
        check8("badchk_result", d, 8'h00);
        @(negedge clk);
        check8("badchk_last_status", last_status, 8'h40);
`endif

        // Make last_status nonzero, then reset in the middle of the next reply.
        do_frame("pre_rst", 8'h01, 8'hFF, 8'h01, 8'h01, 8'h00);
        send_frame(8'h02, 8'h09, 8'h01);
        repeat (2) @(negedge clk);
        check8("mid_valid", {7'd0, bus_if.tx_valid}, 8'h01);
        rst_n = 1'b0;
        #1;
        check8("mrst_tx_valid", {7'd0, bus_if.tx_valid}, 8'h00);
        check8("mrst_tx_data", bus_if.tx_data, 8'h00);
        check8("mrst_busy", {7'd0, busy}, 8'h00);
        check8("mrst_last_status", last_status, 8'h00);
        check8("mrst_rx_drop", {7'd0, rx_drop}, 8'h00);
        check8("mrst_timeout_flag", {7'd0, timeout_flag}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_frame("post_rst", 8'h02, 8'h10, 8'h01, 8'h00, 8'h0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
